// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared state encoding and default pattern
// constants for the frame-level pattern scan controller.
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_PAT_LEN = 5;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 5'b10110;

endpackage

// File: rtl/seq_pattern_det.sv
// seq_pattern_det: overlapping Moore detector over a serial
// bit stream with a registered one-cycle match flag.
module seq_pattern_det
    import seq_scan_pkg::*;
#(
    parameter int PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic bit_valid,
    input  logic bit_in,
    output logic match
);

    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_LEN);
    localparam logic [FW-1:0] NEED = FW'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] hist;
    logic [PAT_LEN-1:0] nxt;
    logic [FW-1:0]      fill;
    logic               primed;

    assign nxt    = PAT_LEN'({hist, bit_in});
    assign primed = (fill >= NEED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else if (clr) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else begin
            match <= bit_valid && primed && (nxt == PATTERN);
            if (bit_valid) begin
                hist <= nxt;
                if (fill != FULL) begin
                    fill <= fill + FW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: accepts words on valid/ready, feeds them MSB-first
// into the pattern detector and counts matches per frame.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_last,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              busy,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count,
    output logic              done
);

    localparam int KW = $clog2(WORD_W);
    localparam logic [KW-1:0] K_LAST = KW'(WORD_W - 1);
    localparam logic [KW-1:0] K_PRE  = KW'(WORD_W - 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [WORD_W-1:0] sreg;
    logic [KW-1:0]     k;
    logic              last_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              clr;
    logic              shifting;
    logic              hs;

    assign clr      = (state == IDLE) && start;
    assign shifting = (state == SHIFT);
    assign hs       = word_valid && word_ready;

    seq_pattern_det #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_det (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .bit_valid (shifting),
        .bit_in    (sreg[WORD_W-1]),
        .match     (match_pulse)
    );

    // cnt_q absorbs each pulse one edge late; adding the live pulse
    // here makes the count step on the same edge as match_pulse.
    assign match_count = (cnt_q == CNT_MAX) ? CNT_MAX
                       : cnt_q + CNT_W'(match_pulse);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sreg       <= '0;
            k          <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            word_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done  <= 1'b0;
            cnt_q <= clr ? '0 : match_count;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= WAIT;
                        word_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                WAIT, SHIFT: begin
                    if (shifting) begin
                        sreg <= sreg << 1;
                        k    <= k + KW'(1);
                    end
                    if (hs) begin
                        state      <= SHIFT;
                        sreg       <= word_in;
                        last_q     <= word_last;
                        k          <= '0;
                        word_ready <= 1'b0;
                    end else if (shifting && k == K_LAST) begin
                        state      <= last_q ? DONE : WAIT;
                        word_ready <= !last_q;
                        done       <= last_q;
                    end else if (shifting) begin
                        word_ready <= (k == K_PRE) && !last_q;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Frame-level controller that sequences a serial Moore pattern detector (default pattern 10110, overlapping) over a stream of parallel words.
- Accepts words on a valid/ready handshake and serializes them MSB-first, one bit per cycle, into a sub-module detector.
- Counts matches per frame, including matches that span word boundaries, and reports completion with a done pulse.
- Sits between a word-oriented producer and the bit-serial detection datapath.

Parameters:
- WORD_W, 8, bits per input word.
- PAT_LEN, 5, pattern length in bits (2..WORD_W).
- PATTERN, 5'b10110, pattern to detect; the first-received bit is the MSB.
- CNT_W, 8, match counter width; the counter saturates.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  opens a frame; honoured only in IDLE.
- word_in  input  WORD_W  data word.
- word_last  input  1  qualifies word_in as the final word of the frame.
- word_valid  input  1  producer has a word.
- word_ready  output  1  controller accepts a word this cycle.
- busy  output  1  high whenever state != IDLE.
- match_pulse  output  1  one-cycle pulse per detected occurrence.
- match_count  output  CNT_W  matches in the current or last frame.
- done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; shift register, bit counter and detector history cleared.
  - word_ready=0, busy=0, match_pulse=0, match_count=0, done=0.
- FSM states: IDLE, WAIT, SHIFT, DONE.
- IDLE:
  - start=1 -> WAIT. On the same edge, match_count clears to 0 and the detector history clears.
  - Without start, words are not accepted (word_ready=0).
- WAIT:
  - word_ready=1.
  - On word_valid&&word_ready, word_in is loaded into the shift register, the last flag is latched, bit counter=0, and the FSM goes to SHIFT.
- SHIFT:
  - Each cycle presents bit word[WORD_W-1-k] to the detector (k = bit counter). The detector samples it at the cycle end.
  - k increments each cycle.
  - At k=WORD_W-1:
    - Latched last=0: word_ready=1 in this cycle. If word_valid, the next word is loaded and SHIFT continues with no bubble; otherwise -> WAIT.
    - Latched last=1: word_ready=0 and the FSM goes to DONE.
  - word_ready=0 at all other k.
- DONE: done=1 for exactly one cycle; match_count is final and valid; then -> IDLE.
- match_count holds its value in IDLE until the next accepted start.
- start in any state other than IDLE is ignored.
- Detector history persists across words within a frame, so boundary-spanning patterns are counted. History is cleared only by start and reset.
- Detector (Moore, overlapping):
  - PAT_LEN-bit history register plus a fill counter.
  - Match when the history after the shift equals PATTERN and at least PAT_LEN bits have been received since clear.
  - match_pulse is registered: it is high in the cycle after the edge that sampled the completing bit.
  - match_count increments on that same edge and saturates at 2^CNT_W-1. match_pulse still fires while saturated.
- Back-pressure: with word_valid=1 and word_ready=0, word_in must be held; the controller samples it only on handshake.
- The final bit's match is visible in the DONE cycle, together with done.
- Throughput: WORD_W cycles per word when the producer streams continuously.

Decomposition:
- Shared package seq_scan_pkg holds:
  - the state enum (IDLE, WAIT, SHIFT, DONE);
  - default constants DEF_PATTERN=5'b10110 and DEF_PAT_LEN=5.
- One sub-module, seq_pattern_det (clk, rst_n, clr, bit_valid, bit_in, match), parameterized by PAT_LEN and PATTERN. It holds the history register, the fill counter and the registered match output.
- seq_scan_ctrl contains the FSM, shift register, bit counter and saturating counter.

Test Plan:
1. Single frame. start, then word 8'hB6 (10110110) with last=1 -> match_pulse 2 times (after bits 4 and 7); match_count=2 in the DONE cycle; done pulse exactly WORD_W+1 cycles after the handshake edge.
2. Boundary span. Words 8'h05 then 8'h80 (last) sent back-to-back -> word_ready high at k=7 of the first word with no bubble; match_count=1.
3. Frame isolation. Frame A ends with ...1011; new start; frame B word 8'h00 (last) -> frame B match_count=0; match_count stays at frame A's value until start.
4. Saturation. CNT_W=2; three words 8'hB6, the third with last=1 -> 6 pulses; match_count=3.
5. Back-pressure. Producer idles 3 cycles between words while the FSM sits in WAIT -> no detector sampling, history preserved, count identical to streamed case 2.
6. Reset and ignored start. rst_n low mid-SHIFT -> outputs immediately return to reset values and IDLE; start pulsed during SHIFT in a normal frame -> no effect on count or state.
